// File: rtl/cbus_arbiter_if.sv
// Cache-bus request/response types and the bundle that carries one cbus port.
// A master drives req and consumes resp; a slave does the opposite.
package cbus_pkg;

    typedef enum logic [1:0] {
        MLEN1 = 2'd0,
        MLEN2 = 2'd1,
        MLEN4 = 2'd2,
        MLEN8 = 2'd3
    } cbus_len_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        cbus_len_t   len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

interface cbus_arbiter_if;
    import cbus_pkg::*;

    cbus_req_t  req;
    cbus_resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);
endinterface

// File: rtl/cbus_arbiter.sv
// Two-to-one cbus arbiter: ICache and DCache share one bridge port, DCache
// preferred, ICache forced after MAX_WAIT waiting cycles. CBUS_ARB_PERF_EN adds counters.
module cbus_arbiter #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 8
) (
    input  logic           clk,
    input  logic           resetn,
    cbus_arbiter_if.slave  icbus,
    cbus_arbiter_if.slave  dcbus,
    cbus_arbiter_if.master obus
`ifdef CBUS_ARB_PERF_EN
    ,
    output logic [31:0]    perf_i_grants,
    output logic [31:0]    perf_d_grants,
    output logic [31:0]    perf_i_wait
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] starve_cnt_reg;
    logic [CNT_W-1:0] starve_cnt_next;
    logic             burst_done;
    logic             i_waiting;

    assign burst_done = obus.resp.ready && obus.resp.last;
    assign i_waiting  = icbus.req.valid && (state_reg != GNT_I);

    // The grant is only re-evaluated from IDLE, so every burst is followed by
    // one bubble and a burst in flight is never pre-empted.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (icbus.req.valid && dcbus.req.valid) begin
                    state_next = (starve_cnt_reg >= MAX_CNT) ? GNT_I : GNT_D;
                end else if (dcbus.req.valid) begin
                    state_next = GNT_D;
                end else if (icbus.req.valid) begin
                    state_next = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (burst_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!icbus.req.valid || (state_next == GNT_I && state_reg != GNT_I)) begin
            starve_cnt_next = '0;
        end else if (i_waiting) begin
            starve_cnt_next = (starve_cnt_reg >= MAX_CNT) ? MAX_CNT
                                                           : starve_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Bus steering decodes purely from the grant state; the losing side sees zeros.
    always_comb begin
        obus.req   = '0;
        icbus.resp = '0;
        dcbus.resp = '0;
        case (state_reg)
            GNT_I: begin
                obus.req   = icbus.req;
                icbus.resp = obus.resp;
            end
            GNT_D: begin
                obus.req   = dcbus.req;
                dcbus.resp = obus.resp;
            end
            default: ;
        endcase
    end

`ifdef CBUS_ARB_PERF_EN
    logic [31:0] perf_i_grants_reg;
    logic [31:0] perf_d_grants_reg;
    logic [31:0] perf_i_wait_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_i_grants_reg <= '0;
            perf_d_grants_reg <= '0;
            perf_i_wait_reg   <= '0;
        end else begin
            if (state_reg == IDLE && state_next == GNT_I) begin
                perf_i_grants_reg <= perf_i_grants_reg + 32'd1;
            end
            if (state_reg == IDLE && state_next == GNT_D) begin
                perf_d_grants_reg <= perf_d_grants_reg + 32'd1;
            end
            if (i_waiting) begin
                perf_i_wait_reg <= perf_i_wait_reg + 32'd1;
            end
        end
    end

    assign perf_i_grants = perf_i_grants_reg;
    assign perf_d_grants = perf_d_grants_reg;
    assign perf_i_wait   = perf_i_wait_reg;
`endif

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: directed scenarios then random traffic, every cycle
// compared against a transaction-level model of who owns the bridge.
module tb_cbus_arbiter;
    import cbus_pkg::*;

    localparam int MAX_WAIT = 16;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    cbus_arbiter_if icbus ();
    cbus_arbiter_if dcbus ();
    cbus_arbiter_if obus ();

`ifdef CBUS_ARB_PERF_EN
    logic [31:0] perf_i_grants;
    logic [31:0] perf_d_grants;
    logic [31:0] perf_i_wait;
`endif

    cbus_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .icbus         (icbus),
        .dcbus         (dcbus),
        .obus          (obus)
`ifdef CBUS_ARB_PERF_EN
        ,
        .perf_i_grants (perf_i_grants),
        .perf_d_grants (perf_d_grants),
        .perf_i_wait   (perf_i_wait)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner 0 = nobody, 1 = ICache, 2 = DCache.
    int          owner  = 0;
    int          starve = 0;
    int          beats  = 0;
    bit [31:0]   m_ig   = 0;
    bit [31:0]   m_dg   = 0;
    bit [31:0]   m_iw   = 0;
    int          m_i_done = 0;
    int          obs_i_done = 0;
    int          obs_i_beats = 0;
    bit          ic_done = 0;
    bit          dc_done = 0;
    int          pi = 0, pd = 0, pr = 100;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int burst_len(input cbus_len_t l);
        return 1 << int'(l);
    endfunction

    task automatic new_ireq(input cbus_len_t l);
        icbus.req.valid    = 1'b1;
        icbus.req.is_write = 1'b0;
        icbus.req.size     = 3'd2;
        icbus.req.addr     = {$urandom_range(32'h0fff_ffff), 4'h0};
        icbus.req.strobe   = 4'h0;
        icbus.req.data     = 32'h0;
        icbus.req.len      = l;
    endtask

    task automatic new_dreq(input bit w, input cbus_len_t l);
        dcbus.req.valid    = 1'b1;
        dcbus.req.is_write = w;
        dcbus.req.size     = 3'($urandom_range(2));
        dcbus.req.addr     = $urandom();
        dcbus.req.strobe   = w ? 4'($urandom_range(15)) : 4'h0;
        dcbus.req.data     = $urandom();
        dcbus.req.len      = l;
    endtask

    task automatic check_outputs();
        cbus_req_t  exp_req;
        cbus_resp_t exp_ir;
        cbus_resp_t exp_dr;
        exp_req = (owner == 1) ? icbus.req : (owner == 2) ? dcbus.req : '0;
        exp_ir  = (owner == 1) ? obus.resp : '0;
        exp_dr  = (owner == 2) ? obus.resp : '0;
        chk("oreq",   96'(obus.req),   96'(exp_req));
        chk("icresp", 96'(icbus.resp), 96'(exp_ir));
        chk("dcresp", 96'(dcbus.resp), 96'(exp_dr));
`ifdef CBUS_ARB_PERF_EN
        chk("perf_i_grants", 96'(perf_i_grants), 96'(m_ig));
        chk("perf_d_grants", 96'(perf_d_grants), 96'(m_dg));
        chk("perf_i_wait",   96'(perf_i_wait),   96'(m_iw));
`endif
        if (icbus.resp.ready) obs_i_beats++;
        if (icbus.resp.ready && icbus.resp.last) obs_i_done++;
    endtask

    // Applies the arbitration rules to the values present just before the edge.
    task automatic model_update();
        bit iv, dv, fin;
        int old;
        iv  = icbus.req.valid;
        dv  = dcbus.req.valid;
        fin = obus.resp.ready && obus.resp.last;
        old = owner;
        if (!resetn) begin
            owner = 0; starve = 0; beats = 0;
            m_ig = 0; m_dg = 0; m_iw = 0;
            ic_done = 0; dc_done = 0;
        end else begin
            if (old == 0) begin
                if (iv && dv) owner = (starve >= MAX_WAIT) ? 1 : 2;
                else if (dv)  owner = 2;
                else if (iv)  owner = 1;
                if (owner == 1) m_ig++;
                if (owner == 2) m_dg++;
            end else begin
                if (obus.resp.ready) beats++;
                if (fin) begin
                    owner = 0;
                    beats = 0;
                    if (old == 1) begin ic_done = 1; m_i_done++; end
                    else dc_done = 1;
                end
            end
            if (iv && old != 1) m_iw++;
            if (!iv || (owner == 1 && old != 1)) starve = 0;
            else if (old != 1) starve = (starve + 1 > MAX_WAIT) ? MAX_WAIT : starve + 1;
        end
    endtask

    task automatic gen_inputs();
        bit rdy;
        resetn = 1'b1;
        if (ic_done) begin icbus.req.valid = 1'b0; ic_done = 0; end
        if (dc_done) begin dcbus.req.valid = 1'b0; dc_done = 0; end
        if (!icbus.req.valid && $urandom_range(99) < pi)
            new_ireq(cbus_len_t'($urandom_range(3)));
        if (!dcbus.req.valid && $urandom_range(99) < pd)
            new_dreq(1'($urandom_range(1)), cbus_len_t'($urandom_range(3)));
        rdy = ($urandom_range(99) < pr);
        obus.resp.ready = rdy;
        obus.resp.data  = $urandom();
        if (owner == 1)      obus.resp.last = rdy && (beats == burst_len(icbus.req.len) - 1);
        else if (owner == 2) obus.resp.last = rdy && (beats == burst_len(dcbus.req.len) - 1);
        else                 obus.resp.last = 1'($urandom_range(1));
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
        gen_inputs();
    endtask

    task automatic run_until_quiet(input string tag);
        int c;
        c = 0;
        while ((icbus.req.valid || dcbus.req.valid || owner != 0) && c < 200) begin
            step();
            c++;
        end
        chk(tag, 96'(c >= 200), 96'(0));
    endtask

    initial begin
        int base;
        resetn    = 1'b0;
        icbus.req = '0;
        dcbus.req = '0;
        obus.resp = '0;
        repeat (2) @(posedge clk);
        #1;
        gen_inputs();

        // Solo ICache 4-beat read, bridge always ready.
        pi = 0; pd = 0; pr = 100;
        new_ireq(MLEN4);
        base = obs_i_beats;
        repeat (8) step();
        chk("solo_i_beats", 96'(obs_i_beats - base), 96'(4));

        // Simultaneous requests: DCache first, then ICache after one bubble.
        new_ireq(MLEN4);
        new_dreq(1'b1, MLEN4);
        repeat (14) step();

        // DCache hammering: ICache must still be served once it has waited long enough.
        base = obs_i_done;
        pd = 100;
        new_ireq(MLEN4);
        repeat (120) step();
        pd = 0;
        run_until_quiet("hammer_timeout");
        chk("starved_i_served", 96'(obs_i_done - base), 96'(1));

        // Uncached single-beat DCache write with ICache arriving behind it.
        pr = 50;
        new_dreq(1'b1, MLEN1);
        step();
        new_ireq(MLEN8);
        run_until_quiet("uncached_timeout");

        // Reset in the middle of a DCache burst.
        pr = 100;
        new_dreq(1'b0, MLEN4);
        for (int c = 0; c < 30 && !(owner == 2 && beats == 2); c++) step();
        chk("reset_reach_beat2", 96'(owner == 2 && beats == 2), 96'(1));
        resetn = 1'b0;
        icbus.req.valid = 1'b0;
        dcbus.req.valid = 1'b0;
        step();
        step();

        // Three ICache and five DCache bursts from a clean counter state.
        pr = 60;
        for (int k = 0; k < 5; k++) begin
            new_dreq(1'($urandom_range(1)), cbus_len_t'($urandom_range(3)));
            if (k < 3) new_ireq(cbus_len_t'($urandom_range(3)));
            run_until_quiet("bursts_timeout");
        end
`ifdef CBUS_ARB_PERF_EN
        chk("perf_i_grants_3", 96'(perf_i_grants), 96'(3));
        chk("perf_d_grants_5", 96'(perf_d_grants), 96'(5));
`endif

        // Random traffic.
        pi = 30; pd = 40; pr = 70;
        repeat (3000) step();
        pi = 0; pd = 0;
        run_until_quiet("random_timeout");
        chk("i_completions", 96'(obs_i_done), 96'(m_i_done));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
